// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs R/I/J-format words and streams them into instruction memory.
// Optional macro ENC_ILLEGAL_TRAP_EN: op_sel 14/15 sets a sticky err instead of writing a NOP.
module instr_encoder #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_sh,
    input logic [5:0]  f_fn,
    input logic [15:0] f_imm,
    input logic [25:0] f_tg
  );
    logic [31:0] w;
    case (op)
      4'd0:    w = {6'h00, f_rs, f_rt, f_rd, f_sh, f_fn};
      4'd1:    w = {6'h08, f_rs, f_rt, f_imm};
      4'd2:    w = {6'h23, f_rs, f_rt, f_imm};
      4'd3:    w = {6'h2b, f_rs, f_rt, f_imm};
      4'd4:    w = {6'h04, f_rs, f_rt, f_imm};
      4'd5:    w = {6'h05, f_rs, f_rt, f_imm};
      4'd6:    w = {6'h0a, f_rs, f_rt, f_imm};
      4'd7:    w = {6'h02, f_tg};
      4'd8:    w = {6'h03, f_tg};
      4'd9:    w = {6'h0c, f_rs, f_rt, f_imm};
      4'd10:   w = {6'h0d, f_rs, f_rt, f_imm};
      4'd11:   w = {6'h0f, 5'd0, f_rt, f_imm};
      4'd12:   w = {6'h06, 5'd0, f_rt, f_rd, f_sh, 6'd0};
      4'd13:   w = {6'h07, 5'd0, f_rt, f_rd, f_sh, 6'd0};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Handshake, write sequencing and pointer/count bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
    end else if (clear) begin
      // an in-flight write is abandoned without counting it
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
`ifdef ENC_ILLEGAL_TRAP_EN
            if (op_sel[3:1] == 3'b111) begin
              err <= 1'b1;
            end else begin
              imem_wdata <= encode(op_sel, rs, rt, rd, shamt, funct, imm, target);
              imem_we    <= 1'b1;
              in_ready   <= 1'b0;
              state      <= S_WRITE;
            end
`else
            imem_wdata <= encode(op_sel, rs, rt, rd, shamt, funct, imm, target);
            imem_we    <= 1'b1;
            in_ready   <= 1'b0;
            state      <= S_WRITE;
`endif
          end
        end
        S_WRITE: begin
          if (!imem_busy) begin
            imem_we <= 1'b0;
            if (count != DEPTH) begin
              count <= count + (AW+1)'(1);
            end
            // the last slot parks the pointer instead of wrapping
            if (imem_addr == {AW{1'b1}}) begin
              done  <= 1'b1;
              state <= S_FULL;
            end else begin
              imem_addr <= imem_addr + AW'(1);
              in_ready  <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          imem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a field-arithmetic reference model.
module tb_instr_encoder;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op_sel = 4'd0;
  logic [4:0]    rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
  logic [5:0]    funct = 6'd0;
  logic [15:0]   imm = 16'd0;
  logic [25:0]   target = 26'd0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_busy = 1'b0;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  instr_encoder #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_busy(imem_busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int exp_ptr = 0;
  int exp_cnt = 0;
  bit exp_full = 1'b0;
  bit exp_err = 1'b0;
  logic [31:0] seen_data;
  logic [31:0] seen_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoding built from field weights and an opcode table.
  function automatic logic [31:0] model_word(input int op, input int a_rs, input int a_rt,
      input int a_rd, input int a_sh, input int a_fn, input int a_imm, input int a_tg);
    int unsigned opc [14] = '{32'h00, 32'h08, 32'h23, 32'h2b, 32'h04, 32'h05, 32'h0a,
                              32'h02, 32'h03, 32'h0c, 32'h0d, 32'h0f, 32'h06, 32'h07};
    int unsigned w;
    if (op > 13) return 32'h0000_0000;
    w = opc[op] * 32'd67108864;
    if (op == 7 || op == 8) return w + 32'(a_tg);
    if (op < 11 || op > 13) w = w + 32'(a_rs) * 32'd2097152;
    w = w + 32'(a_rt) * 32'd65536;
    if (op == 0 || op == 12 || op == 13) begin
      w = w + 32'(a_rd) * 32'd2048 + 32'(a_sh) * 32'd64;
      if (op == 0) w = w + 32'(a_fn);
    end else begin
      w = w + 32'(a_imm);
    end
    return w;
  endfunction

  task automatic send(input int op, input int a_rs, input int a_rt, input int a_rd,
      input int a_sh, input int a_fn, input int a_imm, input int a_tg, input int busy_cyc);
    logic [31:0] w;
    int waited = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("ready_wait", 32'(in_ready), 32'd1);
    if (in_ready !== 1'b1) return;
    op_sel = 4'(op); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd); shamt = 5'(a_sh);
    funct = 6'(a_fn); imm = 16'(a_imm); target = 26'(a_tg);
    in_valid = 1'b1;
    w = model_word(op, a_rs, a_rt, a_rd, a_sh, a_fn, a_imm, a_tg);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_sel = 4'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
`ifdef ENC_ILLEGAL_TRAP_EN
    if (op > 13) begin
      exp_err = 1'b1;
      check_eq("trap_we", 32'(imem_we), 32'd0);
      check_eq("trap_err", 32'(err), 32'd1);
      check_eq("trap_ready", 32'(in_ready), 32'd1);
      check_eq("trap_count", 32'(count), 32'(exp_cnt));
      return;
    end
`endif
    seen_data = imem_wdata;
    seen_addr = 32'(imem_addr);
    check_eq("we_first", 32'(imem_we), 32'd1);
    check_eq("addr", 32'(imem_addr), 32'(exp_ptr));
    check_eq("data", imem_wdata, w);
    check_eq("ready_in_write", 32'(in_ready), 32'd0);
    imem_busy = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("we_hold", 32'(imem_we), 32'd1);
      check_eq("addr_hold", 32'(imem_addr), 32'(exp_ptr));
      check_eq("data_hold", imem_wdata, w);
      check_eq("ready_hold", 32'(in_ready), 32'd0);
      check_eq("count_hold", 32'(count), 32'(exp_cnt));
      if (i == busy_cyc - 1) imem_busy = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    if (exp_ptr == DEPTH - 1) exp_full = 1'b1;
    else exp_ptr++;
    check_eq("we_end", 32'(imem_we), 32'd0);
    check_eq("count", 32'(count), 32'(exp_cnt));
    check_eq("done", 32'(done), 32'(exp_full));
    check_eq("ready_after", 32'(in_ready), 32'(!exp_full));
    check_eq("err", 32'(err), 32'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_busy = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_data", imem_wdata, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready_after", 32'(in_ready), 32'd1);
    exp_ptr = 0; exp_cnt = 0; exp_full = 1'b0; exp_err = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    exp_ptr = 0; exp_cnt = 0; exp_full = 1'b0; exp_err = 1'b0;
    check_eq("clr_ready", 32'(in_ready), 32'd1);
    check_eq("clr_count", 32'(count), 32'd0);
    check_eq("clr_done", 32'(done), 32'd0);
    check_eq("clr_err", 32'(err), 32'd0);
    check_eq("clr_we", 32'(imem_we), 32'd0);
  endtask

  initial begin
    do_reset();

    send(1, 1, 2, 0, 0, 0, 16'h0005, 0, 0);
    check_eq("addi_data", seen_data, 32'h2022_0005);
    check_eq("addi_addr", seen_addr, 32'd0);
    check_eq("addi_count", 32'(count), 32'd1);
    do_clear();

    send(0, 3, 4, 5, 0, 6'h20, 0, 0, 0);
    check_eq("rtype_data", seen_data, 32'h0064_2820);
    check_eq("rtype_addr", seen_addr, 32'd0);
    send(13, 0, 6, 7, 2, 0, 0, 0, 0);
    check_eq("sll_data", seen_data, 32'h1C06_3880);
    check_eq("sll_addr", seen_addr, 32'd1);
    send(8, 0, 0, 0, 0, 0, 0, 26'h0000010, 0);
    check_eq("jal_data", seen_data, 32'h0C00_0010);
    check_eq("jal_addr", seen_addr, 32'd2);
    send(6, 9, 10, 0, 0, 0, 16'hFFFF, 0, 3);
    check_eq("full_done", 32'(done), 32'd1);

    // a request against a full memory must never be accepted
    @(negedge clk);
    in_valid = 1'b1;
    op_sel = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("full_no_we", 32'(imem_we), 32'd0);
      check_eq("full_no_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("full_count", 32'(count), 32'(DEPTH));
    do_clear();

    for (int i = 0; i < DEPTH; i++) begin
      send(2, 0, 1, 0, 0, 0, 4, 0, i % 2);
      check_eq("lw_data", seen_data, 32'h8C01_0004);
      check_eq("lw_addr", seen_addr, 32'(i));
    end
    check_eq("lw_done", 32'(done), 32'd1);
    check_eq("lw_ready", 32'(in_ready), 32'd0);
    do_clear();

    send(14, 1, 2, 3, 4, 5, 6, 7, 0);
`ifdef ENC_ILLEGAL_TRAP_EN
    check_eq("ill_err", 32'(err), 32'd1);
    send(1, 1, 1, 0, 0, 0, 1, 0, 0);
    check_eq("ill_err_sticky", 32'(err), 32'd1);
`else
    check_eq("ill_nop", seen_data, 32'h0000_0000);
    check_eq("ill_err0", 32'(err), 32'd0);
`endif
    do_clear();

    // reset during a stalled write drops it
    send(1, 2, 3, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    op_sel = 4'd2; rs = 5'd1; rt = 5'd2; imm = 16'd8;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    imem_busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_we", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_we", 32'(imem_we), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    imem_busy = 1'b0;
    exp_ptr = 0; exp_cnt = 0; exp_full = 1'b0; exp_err = 1'b0;
    send(10, 4, 5, 0, 0, 0, 16'h1234, 0, 0);
    check_eq("post_rst_addr", seen_addr, 32'd0);

    for (int i = 0; i < 40; i++) begin
      if (exp_full) do_clear();
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 67108863)),
           int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Assembles 32-bit instructions for the single-cycle MIPS datapath and writes them into instruction memory; it is the encoder counterpart of the main control decoder.
- Accepts one operation request per handshake, packs the fields into R/I/J format with the opcode set the decoder recognises, and writes the word at a self-incrementing address.
- Sits between the boot/test loader and the instruction memory write port.

## Interface
- AW, 8, instruction memory address width; capacity DEPTH = 2^AW words
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- clear  input  1  synchronous restart: pointer to 0, state to IDLE, err cleared
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- op_sel  input  4  0 RTYPE, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 SLTI, 7 J, 8 JAL, 9 ANDI, 10 ORI, 11 LI, 12 SRL, 13 SLL, 14–15 illegal
- rs, rt, rd, shamt  input  5 each  register/shift fields
- funct  input  6  R-type function field
- imm  input  16  I-type immediate
- target  input  26  J-type target
- imem_we  output  1  write strobe
- imem_addr  output  AW  write address
- imem_wdata  output  32  encoded instruction
- imem_busy  input  1  memory stall; holds the current write
- done  output  1  memory full
- err  output  1  sticky illegal-op flag (macro dependent)
- count  output  AW+1  words written since reset/clear

## Operation
- Opcodes (hex): RTYPE 00, ADDI 08, LW 23, SW 2b, BEQ 04, BNE 05, SLTI 0a, J 02, JAL 03, ANDI 0c, ORI 0d, LI 0f, SRL 06, SLL 07.
- R-type: {op, rs, rt, rd, shamt, funct}.
- SRL/SLL: {op, 5'b0, rt, rd, shamt, 6'b0}.
- I-type (ADDI, LW, SW, BEQ, BNE, SLTI, ANDI, ORI): {op, rs, rt, imm}.
- LI: {op, 5'b0, rt, imm}.
- J/JAL: {op, target}.
- FSM states:
  - IDLE: in_ready=1. On accept, register the encoded word and go to WRITE.
  - WRITE: imem_we=1 with imem_addr = ptr and imem_wdata = the registered word. Stay while imem_busy=1. When imem_busy=0 the write completes: ptr and count increment. If the completed address was DEPTH-1, go to DONE; otherwise go to IDLE.
  - DONE: done=1, in_ready=0, imem_we=0. Left only by clear or reset.
- ptr is AW bits wide and never wraps; a full memory goes to DONE.
- count saturates at DEPTH.
- clear has priority over every state and an in-flight write is abandoned: no increment, imem_we=0 next cycle. rst_n has priority over clear.
- Request fields are sampled only on the accept cycle; changes after accept do not affect the word.

## Timing
- Reset values: in_ready=0 during reset and 1 in the cycle after. imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, count=0.
- Latency: accept at edge N, imem_we high in cycle N+1. Best case is one word per 2 cycles.
- in_ready=0 in WRITE and DONE, so there is no back-to-back acceptance.
- imem_addr and imem_wdata are stable for the whole time imem_we is high.
- Reset mid-write drops the write; the memory sees imem_we low from the next cycle.

## Configuration
- ENC_ILLEGAL_TRAP_EN defined: op_sel 14/15 is accepted and consumed with no write, err sets and stays set until clear/reset, and the state remains IDLE.
- ENC_ILLEGAL_TRAP_EN undefined: op_sel 14/15 writes 32'h00000000 (NOP) like a normal request, and err is tied to 0.

## Test plan
- ADDI rs=1 rt=2 imm=16'h0005 after reset -> one-cycle imem_we at addr 0, data 32'h20220005, count=1.
- RTYPE rs=3 rt=4 rd=5 funct=6'h20, then SLL rt=6 rd=7 shamt=2, then JAL target=26'h0000010 -> writes at addr 0, 1, 2 with data 32'h00642820, 32'h1C063880, 32'h0C000010.
- imem_busy high for 3 cycles during a write -> imem_we, addr and data held for 4 cycles, in_ready=0 throughout, count increments once.
- AW=2, 4 LW rs=0 rt=1 imm=4 -> data 32'h8C010004 at addr 0–3, done=1, in_ready=0. A 5th in_valid is not accepted. clear -> in_ready=1, count=0, next write at addr 0.
- op_sel=14 with ENC_ILLEGAL_TRAP_EN -> no imem_we, err=1 and sticky. Without the macro -> 32'h00000000 written, err=0.
- Reset asserted during WRITE with imem_busy=1 -> imem_we=0 and count=0 the next cycle, and the next accepted word goes to addr 0.
